// File: rtl/sr04_sched_pkg.sv
// Shared types and widths for the SR04 measurement scheduler.
// Optional build macro: SR04_SCHED_AVG_EN (4-sample moving average).
package sr04_sched_pkg;

   localparam int DIST_W    = 10;
   localparam int MS_CNT_W  = 16;
   localparam int AVG_DEPTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TRIG = 2'd1,
      ST_WAIT = 2'd2,
      ST_HOLD = 2'd3
   } state_e;

endpackage

// File: rtl/sr04_ms_tick.sv
// Cycle counter producing a one-cycle ms_tick every CLK_PER_MS clocks.
// A synchronous clear restarts the millisecond phase.
module sr04_ms_tick #(
   parameter int CLK_PER_MS = 100000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic ms_tick
);

   localparam int CW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_PER_MS - 1);

   logic [CW-1:0] cyc_q, cyc_d;

   // Next count: clear wins, otherwise wrap at LAST and tick
   always_comb begin
      ms_tick = 1'b0;
      cyc_d   = cyc_q + CW'(1);
      if (clr) begin
         cyc_d = '0;
      end else if (cyc_q == LAST) begin
         cyc_d   = '0;
         ms_tick = 1'b1;
      end
   end

   // Cycle counter register
   always_ff @(posedge clk) begin
      if (rst) cyc_q <= '0;
      else     cyc_q <= cyc_d;
   end

endmodule

// File: rtl/sr04_scheduler.sv
// SR04 measurement sequencer: start pulses, timeout, re-trigger holdoff.
// Optional build macro: SR04_SCHED_AVG_EN (averages last 4 accepted samples).
module sr04_scheduler
   import sr04_sched_pkg::*;
#(
   parameter int CLK_PER_MS = 100000,
   parameter int PERIOD_MS  = 60,
   parameter int TIMEOUT_MS = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        single_req,
   input  logic        dist_done,
   input  logic [9:0]  distance,
   output logic        start,
   output logic [9:0]  dist_out,
   output logic        dist_valid,
   output logic        timeout_err,
   output logic        busy
);

   localparam logic [MS_CNT_W-1:0] PERIOD_C  = MS_CNT_W'(PERIOD_MS);
   localparam logic [MS_CNT_W-1:0] TIMEOUT_C = MS_CNT_W'(TIMEOUT_MS);

   state_e              state_q, state_d;
   logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
   logic                start_q, start_d;
   logic [DIST_W-1:0]   dist_out_q, dist_out_d;
   logic                dist_valid_q, dist_valid_d;
   logic                timeout_err_q, timeout_err_d;
   logic                ms_tick;
   logic                cnt_clr;
   logic                accept;
   logic                tmo;

   assign cnt_clr = (state_q == ST_TRIG);

   sr04_ms_tick #(
      .CLK_PER_MS (CLK_PER_MS)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .ms_tick (ms_tick)
   );

   // FSM next state; dist_done beats a coincident timeout
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      tmo     = 1'b0;
      unique case (state_q)
         ST_IDLE: if (enable || single_req) state_d = ST_TRIG;
         ST_TRIG: state_d = ST_WAIT;
         ST_WAIT: begin
            if (dist_done) begin
               accept  = 1'b1;
               state_d = ST_HOLD;
            end else if (ms_cnt_q == TIMEOUT_C) begin
               tmo     = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (ms_cnt_q == PERIOD_C)
               state_d = enable ? ST_TRIG : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Millisecond counter, restarted at every trigger
   always_comb begin
      ms_cnt_d = ms_cnt_q;
      if (cnt_clr)      ms_cnt_d = '0;
      else if (ms_tick) ms_cnt_d = ms_cnt_q + MS_CNT_W'(1);
   end

   // Registered start pulse and sticky timeout flag
   always_comb begin
      start_d       = (state_d == ST_TRIG);
      timeout_err_d = timeout_err_q;
      if (accept)   timeout_err_d = 1'b0;
      else if (tmo) timeout_err_d = 1'b1;
   end

`ifdef SR04_SCHED_AVG_EN
   logic [DIST_W-1:0] hist_q [AVG_DEPTH];
   logic [DIST_W-1:0] hist_d [AVG_DEPTH];
   logic              filled_q, filled_d;
   logic              avg_pend_q, avg_pend_d;
   logic [DIST_W+1:0] sum;

   // History shift; first sample primes every entry
   always_comb begin
      hist_d     = hist_q;
      filled_d   = filled_q;
      avg_pend_d = accept;
      if (accept) begin
         filled_d = 1'b1;
         if (!filled_q) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = distance;
         end else begin
            for (int i = AVG_DEPTH - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
            hist_d[0] = distance;
         end
      end
   end

   // Average of the history, published one cycle after it updates
   always_comb begin
      sum = '0;
      for (int i = 0; i < AVG_DEPTH; i++)
         sum = sum + (DIST_W+2)'(hist_q[i]);
      dist_out_d   = avg_pend_q ? sum[DIST_W+1:2] : dist_out_q;
      dist_valid_d = avg_pend_q;
   end

   // History registers
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
         filled_q   <= 1'b0;
         avg_pend_q <= 1'b0;
      end else begin
         hist_q     <= hist_d;
         filled_q   <= filled_d;
         avg_pend_q <= avg_pend_d;
      end
   end
`else
   // Raw capture of the accepted distance
   always_comb begin
      dist_out_d   = accept ? distance : dist_out_q;
      dist_valid_d = accept;
   end
`endif

   // Main state and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         ms_cnt_q      <= '0;
         start_q       <= 1'b0;
         dist_out_q    <= '0;
         dist_valid_q  <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ms_cnt_q      <= ms_cnt_d;
         start_q       <= start_d;
         dist_out_q    <= dist_out_d;
         dist_valid_q  <= dist_valid_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign start       = start_q;
   assign dist_out    = dist_out_q;
   assign dist_valid  = dist_valid_q;
   assign timeout_err = timeout_err_q;
   assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr04_scheduler.sv
// Directed self-checking bench for sr04_scheduler.
// Build with SR04_SCHED_AVG_EN to exercise the averaging path instead.
module tb_sr04_scheduler;
   import sr04_sched_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic       single_req;
   logic       dist_done;
   logic [9:0] distance;
   logic       start;
   logic [9:0] dist_out;
   logic       dist_valid;
   logic       timeout_err;
   logic       busy;

   int nchk   = 0;
   int nfail  = 0;
   int cyc    = 0;
   int nstart = 0;
   int nvalid = 0;

   sr04_scheduler #(
      .CLK_PER_MS (10),
      .PERIOD_MS  (6),
      .TIMEOUT_MS (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .single_req  (single_req),
      .dist_done   (dist_done),
      .distance    (distance),
      .start       (start),
      .dist_out    (dist_out),
      .dist_valid  (dist_valid),
      .timeout_err (timeout_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (start === 1'b1)      nstart++;
      if (dist_valid === 1'b1) nvalid++;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic at(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_start(output int s);
      for (int i = 0; i < 200; i++) begin
         if (start === 1'b1) break;
         step(1);
      end
      chk("start_seen", 32'(start), 32'd1);
      s = cyc;
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 200; i++) begin
         if (busy === 1'b0) break;
         step(1);
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   task automatic shot(output int s);
      single_req = 1'b1;
      step(1);
      single_req = 1'b0;
      wait_start(s);
   endtask

   task automatic respond(input int c, input logic [9:0] d);
      at(c);
      dist_done = 1'b1;
      distance  = d;
      step(1);
      dist_done = 1'b0;
   endtask

   initial begin
      int s, s1, s2, s3, vb, nb;
      rst        = 1'b1;
      enable     = 1'b0;
      single_req = 1'b0;
      dist_done  = 1'b0;
      distance   = '0;
      step(3);
      chk("rst_start", 32'(start), 32'd0);
      chk("rst_dist_out", 32'(dist_out), 32'd0);
      chk("rst_valid", 32'(dist_valid), 32'd0);
      chk("rst_tmo", 32'(timeout_err), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
      rst = 1'b0;
      step(2);

`ifdef SR04_SCHED_AVG_EN
      begin
         logic [9:0] smp [4];
         logic [9:0] avg [4];
         smp = '{10'd100, 10'd200, 10'd200, 10'd200};
         avg = '{10'd100, 10'd125, 10'd150, 10'd175};
         for (int k = 0; k < 4; k++) begin
            shot(s);
            respond(s + 15, smp[k]);
            chk("avg_n1_valid", 32'(dist_valid), 32'd0);
            step(1);
            chk("avg_n2_valid", 32'(dist_valid), 32'd1);
            chk("avg_out", 32'(dist_out), 32'(avg[k]));
            wait_idle();
         end
         shot(s);
         wait_idle();
         chk("avg_tmo_flag", 32'(timeout_err), 32'd1);
         chk("avg_tmo_hold", 32'(dist_out), 32'd175);
         shot(s);
         respond(s + 15, 10'd200);
         step(1);
         chk("avg_after_tmo", 32'(dist_out), 32'd200);
         chk("avg_tmo_clr", 32'(timeout_err), 32'd0);
         wait_idle();
      end
`else
      shot(s);
      respond(s + 15, 10'd123);
      chk("single_out", 32'(dist_out), 32'd123);
      chk("single_valid", 32'(dist_valid), 32'd1);
      step(1);
      chk("single_valid_1cyc", 32'(dist_valid), 32'd0);
      at(s + 61);
      chk("single_busy_hold", 32'(busy), 32'd1);
      step(1);
      chk("single_busy_drop", 32'(busy), 32'd0);
      chk("single_idle", 32'(dut.state_q), 32'(ST_IDLE));
      step(70);
      chk("single_one_start", 32'(nstart), 32'd1);

      vb = nvalid;
      enable = 1'b1;
      wait_start(s1);
      respond(s1 + 15, 10'd50);
      chk("auto_out", 32'(dist_out), 32'd50);
      wait_start(s2);
      chk("auto_space1", 32'(s2 - s1), 32'd62);
      chk("auto_valid1", 32'(nvalid - vb), 32'd1);
      respond(s2 + 15, 10'd50);
      wait_start(s3);
      chk("auto_space2", 32'(s3 - s2), 32'd62);
      chk("auto_valid2", 32'(nvalid - vb), 32'd2);
      at(s3 + 5);
      enable = 1'b0;
      respond(s3 + 15, 10'd51);
      chk("drop_out", 32'(dist_out), 32'd51);
      at(s3 + 61);
      chk("drop_hold", 32'(dut.state_q), 32'(ST_HOLD));
      step(1);
      chk("drop_idle", 32'(dut.state_q), 32'(ST_IDLE));
      nb = nstart;
      step(80);
      chk("drop_no_start", 32'(nstart), 32'(nb));

      shot(s);
      vb = nvalid;
      at(s + 40);
      chk("tmo_early", 32'(timeout_err), 32'd0);
      at(s + 42);
      chk("tmo_set", 32'(timeout_err), 32'd1);
      chk("tmo_hold_out", 32'(dist_out), 32'd51);
      wait_idle();
      chk("tmo_no_valid", 32'(nvalid), 32'(vb));

      shot(s);
      respond(s + 15, 10'd77);
      chk("rec_out", 32'(dist_out), 32'd77);
      chk("rec_tmo_clr", 32'(timeout_err), 32'd0);
      wait_idle();

      shot(s);
      wait_idle();
      chk("tmo2_set", 32'(timeout_err), 32'd1);

      shot(s);
      nb = nstart;
      at(s + 5);
      single_req = 1'b1;
      step(1);
      single_req = 1'b0;
      respond(s + 41, 10'd300);
      chk("tie_out", 32'(dist_out), 32'd300);
      chk("tie_valid", 32'(dist_valid), 32'd1);
      chk("tie_tmo_clr", 32'(timeout_err), 32'd0);
      respond(s + 50, 10'd999);
      chk("hold_ign_valid", 32'(dist_valid), 32'd0);
      chk("hold_ign_out", 32'(dist_out), 32'd300);
      wait_idle();
      step(10);
      chk("wait_req_ignored", 32'(nstart), 32'(nb + 1));

      shot(s);
      at(s + 10);
      rst = 1'b1;
      step(1);
      chk("mid_rst_start", 32'(start), 32'd0);
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_out", 32'(dist_out), 32'd0);
      rst = 1'b0;
      nb = nstart;
      step(20);
      chk("mid_rst_no_start", 32'(nstart), 32'(nb));
`endif

      $display("%0d/%0d checks passed", nchk - nfail, nchk);
      $finish;
   end

endmodule
